// File: rtl/vram_arbiter_if.sv
// Bus bundle between the sync generator, drawing logic, framebuffer RAM and the VRAM arbiter.
// The slave modport is the arbiter's view; master is the surrounding system.
interface vram_arbiter_if #(
  parameter int unsigned ADDR_W = 19,
  parameter int unsigned DATA_W = 8
);
  logic [9:0]        h_counter;
  logic [9:0]        v_counter;
  logic              v_en;
  logic              h_sync_in;
  logic              v_sync_in;
  logic              wr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rdata;
  logic [DATA_W-1:0] pixel_out;
  logic              pixel_valid;
  logic              h_sync_out;
  logic              v_sync_out;
  logic [2:0]        pending;

  modport slave (
    input  h_counter, v_counter, v_en, h_sync_in, v_sync_in,
    input  wr_req, wr_addr, wr_data, mem_rdata,
    output wr_ready, mem_addr, mem_wdata, mem_we,
    output pixel_out, pixel_valid, h_sync_out, v_sync_out, pending
  );

  modport master (
    output h_counter, v_counter, v_en, h_sync_in, v_sync_in,
    output wr_req, wr_addr, wr_data, mem_rdata,
    input  wr_ready, mem_addr, mem_wdata, mem_we,
    input  pixel_out, pixel_valid, h_sync_out, v_sync_out, pending
  );
endinterface

// File: rtl/vram_arbiter.sv
// Single-port framebuffer scheduler: display fetch owns active-region cycles,
// posted writes wait in a small FIFO and drain during blanking.
module vram_arbiter #(
  parameter int unsigned ADDR_W     = 19,
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned H_ACTIVE   = 640,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input logic           clk,
  input logic           rst_n,
  vram_arbiter_if.slave bus
);
  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned PROD_W = 32;

  typedef enum logic [1:0] {IDLE = 2'b00, FETCH = 2'b01, DRAIN = 2'b10} state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_entry_t;

  state_e            state_q, state_d;
  wr_entry_t         fifo_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  count_q;
  logic              push_c, pop_c;
  logic [ADDR_W-1:0] fetch_addr_c;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [1:0]        ven_sr_q, hs_sr_q, vs_sr_q;
  logic [DATA_W-1:0] pixel_out_q;
  logic              pixel_valid_q, h_sync_out_q, v_sync_out_q;

  // Acceptance looks only at registered occupancy, so a full FIFO refuses even on a pop cycle.
  assign bus.wr_ready = (count_q < CNT_W'(FIFO_DEPTH));
  assign fetch_addr_c = ADDR_W'(PROD_W'(bus.v_counter) * PROD_W'(H_ACTIVE) + PROD_W'(bus.h_counter));

  // Next memory operation: fetch wins whenever the raster is active.
  always_comb begin
    state_d     = IDLE;
    push_c      = bus.wr_req & bus.wr_ready;
    pop_c       = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if (bus.v_en) begin
      state_d    = FETCH;
      mem_addr_d = fetch_addr_c;
    end else if (count_q != '0) begin
      state_d     = DRAIN;
      pop_c       = 1'b1;
      mem_addr_d  = fifo_q[rd_ptr_q].addr;
      mem_wdata_d = fifo_q[rd_ptr_q].data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      wr_ptr_q    <= wr_ptr_q + PTR_W'(push_c);
      rd_ptr_q    <= rd_ptr_q + PTR_W'(pop_c);
      count_q     <= count_q + CNT_W'(push_c) - CNT_W'(pop_c);
    end
  end

  // Payload storage needs no reset; occupancy guards every read.
  always_ff @(posedge clk) begin
    if (push_c) fifo_q[wr_ptr_q] <= '{addr: bus.wr_addr, data: bus.wr_data};
  end

  // Active flag and syncs ride a 3-stage delay matching address + RAM latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ven_sr_q      <= '0;
      hs_sr_q       <= '0;
      vs_sr_q       <= '0;
      pixel_out_q   <= '0;
      pixel_valid_q <= 1'b0;
      h_sync_out_q  <= 1'b0;
      v_sync_out_q  <= 1'b0;
    end else begin
      ven_sr_q      <= {ven_sr_q[0], bus.v_en};
      hs_sr_q       <= {hs_sr_q[0], bus.h_sync_in};
      vs_sr_q       <= {vs_sr_q[0], bus.v_sync_in};
      pixel_out_q   <= ven_sr_q[1] ? bus.mem_rdata : '0;
      pixel_valid_q <= ven_sr_q[1];
      h_sync_out_q  <= hs_sr_q[1];
      v_sync_out_q  <= vs_sr_q[1];
    end
  end

  assign bus.mem_addr    = mem_addr_q;
  assign bus.mem_wdata   = mem_wdata_q;
  assign bus.mem_we      = (state_q == DRAIN);
  assign bus.pending     = count_q;
  assign bus.pixel_out   = pixel_out_q;
  assign bus.pixel_valid = pixel_valid_q;
  assign bus.h_sync_out  = h_sync_out_q;
  assign bus.v_sync_out  = v_sync_out_q;
endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: directed corner sequences, an address table and
// randomized traffic scored against a queue-based model of the scheduling rules.
module tb_vram_arbiter;
  localparam int unsigned ADDR_W   = 19;
  localparam int unsigned DATA_W   = 8;
  localparam int unsigned H_ACTIVE = 640;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  vram_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  vram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .H_ACTIVE(H_ACTIVE), .FIFO_DEPTH(4)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // Synchronous single-port framebuffer RAM
  logic [7:0] ram [0:(1<<ADDR_W)-1];
  always @(posedge clk) begin
    if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
    bus.mem_rdata <= ram[bus.mem_addr];
  end

  function automatic logic [7:0] init_val(int unsigned a);
    return 8'(a ^ (a >> 8));
  endfunction

  // Reference model state
  typedef struct packed {logic [ADDR_W-1:0] addr; logic [7:0] data;} wr_t;
  typedef struct packed {logic valid; logic [7:0] data; logic hs; logic vs;} pix_t;
  wr_t               mq[$];
  pix_t              pq[$];
  logic [7:0]        fb [int unsigned];
  logic [ADDR_W-1:0] e_addr;
  logic [7:0]        e_wdata;
  logic              e_we;
  int                errors = 0;
  int                checks = 0;

  function automatic logic [7:0] fb_read(logic [ADDR_W-1:0] a);
    int unsigned k = 32'(a);
    return fb.exists(k) ? fb[k] : init_val(k);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    pq.delete();
    pq.push_back('0);
    pq.push_back('0);
    e_addr  = '0;
    e_wdata = '0;
    e_we    = 1'b0;
  endtask

  // One clock: predict from current inputs, advance, then score every output.
  task automatic step(output logic accepted);
    pix_t pe, po;
    wr_t  w;
    if (e_we) fb[32'(e_addr)] = e_wdata;
    check("wr_ready", 32'(bus.wr_ready), 32'(mq.size() < 4));
    accepted = bus.wr_req && (mq.size() < 4);
    pe = '0;
    pe.hs = bus.h_sync_in;
    pe.vs = bus.v_sync_in;
    if (bus.v_en) begin
      e_addr   = ADDR_W'(32'(bus.v_counter) * H_ACTIVE + 32'(bus.h_counter));
      e_we     = 1'b0;
      pe.valid = 1'b1;
      pe.data  = fb_read(e_addr);
    end else if (mq.size() > 0) begin
      w       = mq.pop_front();
      e_addr  = w.addr;
      e_wdata = w.data;
      e_we    = 1'b1;
    end else begin
      e_we = 1'b0;
    end
    if (accepted) begin
      w.addr = bus.wr_addr;
      w.data = bus.wr_data;
      mq.push_back(w);
    end
    pq.push_back(pe);
    po = pq.pop_front();
    @(posedge clk);
    #1;
    check("mem_we", 32'(bus.mem_we), 32'(e_we));
    check("mem_addr", 32'(bus.mem_addr), 32'(e_addr));
    if (e_we) check("mem_wdata", 32'(bus.mem_wdata), 32'(e_wdata));
    check("pending", 32'(bus.pending), 32'(mq.size()));
    check("pixel_valid", 32'(bus.pixel_valid), 32'(po.valid));
    check("pixel_out", 32'(bus.pixel_out), 32'(po.data));
    check("h_sync_out", 32'(bus.h_sync_out), 32'(po.hs));
    check("v_sync_out", 32'(bus.v_sync_out), 32'(po.vs));
  endtask

  task automatic drive(input logic ven, input logic [9:0] v, input logic [9:0] h,
                       input logic req, input logic [ADDR_W-1:0] a, input logic [7:0] d);
    bus.v_en      = ven;
    bus.v_counter = v;
    bus.h_counter = h;
    bus.wr_req    = req;
    bus.wr_addr   = a;
    bus.wr_data   = d;
  endtask

  typedef struct {logic [9:0] v; logic [9:0] h; logic [ADDR_W-1:0] exp;} vec_t;
  vec_t tbl[6];

  initial begin
    logic acc;
    int   got[5];
    int   ngot;
    int   we_seen;
    int   run;

    tbl[0] = '{10'd0,   10'd0,    19'd0};
    tbl[1] = '{10'd2,   10'd5,    19'd1285};
    tbl[2] = '{10'd1,   10'd0,    19'd640};
    tbl[3] = '{10'd479, 10'd639,  19'd307199};
    tbl[4] = '{10'd1023, 10'd1023, 19'd131455};
    tbl[5] = '{10'd819, 10'd1023, 19'd895};

    for (int i = 0; i < (1 << ADDR_W); i++) ram[i] = init_val(i);
    bus.h_sync_in = 1'b1;
    bus.v_sync_in = 1'b1;
    drive(1'b1, 10'd3, 10'd4, 1'b1, 19'd5, 8'h11);

    // Reset held with a pending request
    repeat (3) @(posedge clk);
    #1;
    check("rst_mem_we", 32'(bus.mem_we), 32'd0);
    check("rst_pending", 32'(bus.pending), 32'd0);
    check("rst_wr_ready", 32'(bus.wr_ready), 32'd1);
    check("rst_pixel_valid", 32'(bus.pixel_valid), 32'd0);
    check("rst_pixel_out", 32'(bus.pixel_out), 32'd0);
    check("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
    check("rst_mem_wdata", 32'(bus.mem_wdata), 32'd0);
    check("rst_h_sync_out", 32'(bus.h_sync_out), 32'd0);
    check("rst_v_sync_out", 32'(bus.v_sync_out), 32'd0);
    rst_n = 1'b1;
    model_reset();
    step(acc);
    check("post_rst_accept", 32'(acc), 32'd1);
    check("post_rst_pending", 32'(bus.pending), 32'd1);
    bus.wr_req = 1'b0;
    drive(1'b0, 10'd0, 10'd0, 1'b0, 19'd0, 8'h00);
    repeat (2) step(acc);

    // Fetch address table
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, tbl[i].v, tbl[i].h, 1'b0, 19'd0, 8'h00);
      bus.h_sync_in = 1'(i);
      step(acc);
      check("tbl_addr", 32'(bus.mem_addr), 32'(tbl[i].exp));
    end

    // Posted write held through active, issued on first blanking cycle
    drive(1'b1, 10'd0, 10'd0, 1'b1, 19'd100, 8'h3C);
    step(acc);
    bus.wr_req = 1'b0;
    check("post_pending", 32'(bus.pending), 32'd1);
    repeat (2) begin
      step(acc);
      check("post_no_we_active", 32'(bus.mem_we), 32'd0);
    end
    bus.v_en = 1'b0;
    step(acc);
    check("post_we", 32'(bus.mem_we), 32'd1);
    check("post_addr", 32'(bus.mem_addr), 32'd100);
    check("post_wdata", 32'(bus.mem_wdata), 32'h3C);
    check("post_pending0", 32'(bus.pending), 32'd0);

    // Blanking write becomes visible to the following fetch, 3-cycle pixel latency
    drive(1'b0, 10'd0, 10'd0, 1'b1, 19'd1285, 8'hA5);
    step(acc);
    bus.wr_req = 1'b0;
    step(acc);
    drive(1'b1, 10'd2, 10'd5, 1'b0, 19'd0, 8'h00);
    step(acc);
    check("fetch_addr", 32'(bus.mem_addr), 32'd1285);
    check("fetch_we", 32'(bus.mem_we), 32'd0);
    bus.v_en = 1'b0;
    step(acc);
    step(acc);
    check("pix_valid", 32'(bus.pixel_valid), 32'd1);
    check("pix_data", 32'(bus.pixel_out), 32'hA5);
    step(acc);
    check("pix_valid_off", 32'(bus.pixel_valid), 32'd0);

    // Backpressure: fifth request refused and held
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 10'd1, 10'(i), 1'b1, 19'(200 + i), 8'(i));
      if (i == 4) begin
        check("bp_ready", 32'(bus.wr_ready), 32'd0);
        check("bp_pending", 32'(bus.pending), 32'd4);
      end
      step(acc);
    end
    check("bp_held", 32'(acc), 32'd0);
    bus.v_en = 1'b0;
    ngot = 0;
    for (int i = 0; i < 5; i++) got[i] = -1;
    for (int c = 0; c < 12 && ngot < 5; c++) begin
      step(acc);
      if (acc) bus.wr_req = 1'b0;
      if (bus.mem_we) begin
        got[ngot] = int'(bus.mem_addr);
        ngot++;
      end
    end
    for (int i = 0; i < 5; i++) check("bp_order", 32'(got[i]), 32'(200 + i));

    // Simultaneous push and pop keeps occupancy
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 10'd0, 10'd0, 1'b1, 19'(300 + i), 8'(i));
      step(acc);
    end
    drive(1'b0, 10'd0, 10'd0, 1'b1, 19'd302, 8'h22);
    step(acc);
    check("pp_pending", 32'(bus.pending), 32'd2);
    check("pp_we", 32'(bus.mem_we), 32'd1);
    check("pp_addr", 32'(bus.mem_addr), 32'd300);
    bus.wr_req = 1'b0;
    repeat (3) step(acc);

    // Reset during drain drops the in-flight write and the queue
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 10'd0, 10'd0, 1'b1, 19'(400 + i), 8'(i + 8'h40));
      step(acc);
    end
    drive(1'b0, 10'd0, 10'd0, 1'b0, 19'd0, 8'h00);
    step(acc);
    check("rd_we_before", 32'(bus.mem_we), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rd_we_async", 32'(bus.mem_we), 32'd0);
    check("rd_pending_async", 32'(bus.pending), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    we_seen = 0;
    repeat (6) begin
      step(acc);
      if (bus.mem_we) we_seen++;
    end
    check("rd_no_stale", 32'(we_seen), 32'd0);

    // Randomized traffic against the model
    run = 0;
    for (int c = 0; c < 3000; c++) begin
      if (run == 0) begin
        bus.v_en = ~bus.v_en;
        run = int'($urandom_range(1, 20));
      end
      run--;
      bus.v_counter = 10'($urandom_range(0, 7));
      bus.h_counter = 10'($urandom_range(0, 31));
      bus.h_sync_in = 1'($urandom);
      bus.v_sync_in = 1'($urandom);
      bus.wr_req    = 1'($urandom);
      bus.wr_addr   = 19'($urandom_range(0, 7 * 640 + 31));
      bus.wr_data   = 8'($urandom);
      step(acc);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/vram_arbiter.md
Name: vram_arbiter

Overview:
- Schedules the single-port framebuffer between two users: display pixel fetch (driven by the sync generator's H/V counters and V_EN) and a posted-write port for drawing logic.
- Display reads own the memory in every active-region cycle. Writes are buffered in a 4-entry FIFO and drained only when V_EN is low.
- Display pixel data and sync are delayed together so they stay aligned at the DAC.

Parameters:
- ADDR_W, 19, framebuffer word-address width (640*480 = 307200 words)
- DATA_W, 8, pixel/word width
- H_ACTIVE, 640, pixels per active line (row stride)
- FIFO_DEPTH, 4, posted-write entries (fixed power of two)

Ports:
- CLOCK  in  1  pixel clock, same as the sync generator
- RESET_N  in  1  asynchronous active-low reset
- H_COUNTER  in  10  current horizontal pixel from the sync generator
- V_COUNTER  in  10  current line from the sync generator
- V_EN  in  1  active-region flag from the sync generator
- H_SYNC_IN  in  1  raw horizontal sync
- V_SYNC_IN  in  1  raw vertical sync
- WR_REQ  in  1  write request
- WR_ADDR  in  ADDR_W  write address
- WR_DATA  in  DATA_W  write data
- WR_READY  out  1  FIFO can accept; a write is taken when WR_REQ & WR_READY
- MEM_ADDR  out  ADDR_W  registered memory address
- MEM_WDATA  out  DATA_W  registered write data
- MEM_WE  out  1  registered write enable
- MEM_RDATA  in  DATA_W  synchronous read data, valid 1 cycle after MEM_ADDR
- PIXEL_OUT  out  DATA_W  pixel to the DAC
- PIXEL_VALID  out  1  PIXEL_OUT belongs to the active region
- H_SYNC_OUT  out  1  H_SYNC_IN delayed 3 cycles
- V_SYNC_OUT  out  1  V_SYNC_IN delayed 3 cycles
- PENDING  out  3  FIFO occupancy, 0..4

Behaviour:
- Reset (asynchronous, RESET_N=0):
  - MEM_ADDR=0, MEM_WDATA=0, MEM_WE=0.
  - PIXEL_OUT=0, PIXEL_VALID=0, H_SYNC_OUT=0, V_SYNC_OUT=0.
  - FIFO empty, PENDING=0, WR_READY=1, state IDLE.
- WR_READY is combinational: 1 when PENDING<4. It is based on registered occupancy only, so a push is refused when the FIFO is full even if a pop happens in the same cycle.
- FSM (state names the memory operation issued at the next edge). Decision made in cycle t from V_EN(t) and PENDING(t):
  - FETCH if V_EN=1.
  - DRAIN if V_EN=0 and PENDING>0.
  - IDLE otherwise.
- FETCH:
  - MEM_ADDR <= V_COUNTER*H_ACTIVE + H_COUNTER, computed at full width and truncated to ADDR_W.
  - MEM_WE <= 0.
- DRAIN:
  - Pop the FIFO head; MEM_ADDR/MEM_WDATA <= head; MEM_WE <= 1.
  - Exactly one write per cycle, in FIFO order.
- IDLE: MEM_WE <= 0; MEM_ADDR holds its previous value.
- A write is never issued in a cycle whose decision saw V_EN=1. Display reads are never stalled.
- Push and pop in the same cycle (FIFO not full): both happen; PENDING is unchanged.
- Pointers wrap modulo 4.
- Pixel pipeline, latency 3 from counter sample (t) to PIXEL_OUT (t+3):
  - t+1: address registered.
  - t+2: MEM_RDATA valid.
  - t+3: PIXEL_OUT <= MEM_RDATA, PIXEL_VALID <= V_EN delayed 3.
  - When the delayed V_EN is 0, PIXEL_OUT <= 0.
- Sync outputs use the same 3-stage delay, so sync and pixel stay aligned.
- Ordering: a write drained in blanking becomes visible from the next active region onward. Read-after-write within the same active region is not guaranteed.
- Reset mid-drain: all pending FIFO entries are discarded; the in-flight MEM_WE is forced to 0 immediately.

Test Plan:
- Reset: hold RESET_N=0 with WR_REQ=1 -> MEM_WE=0, PENDING=0, WR_READY=1, PIXEL_VALID=0, all outputs 0; after release, first write is accepted next edge.
- Fetch address: V_EN=1, V_COUNTER=2, H_COUNTER=5 at cycle t -> MEM_ADDR=1285 at t+1, MEM_WE=0. Drive MEM_RDATA=0xA5 at t+2 -> PIXEL_OUT=0xA5 and PIXEL_VALID=1 at t+3.
- Posted write during active: V_EN=1, push (addr 100, data 0x3C) -> PENDING=1, no MEM_WE while V_EN=1. At the first cycle with V_EN=0 -> next edge MEM_WE=1, MEM_ADDR=100, MEM_WDATA=0x3C, PENDING=0.
- Backpressure: 5 consecutive WR_REQ during active -> first 4 accepted, WR_READY=0 and PENDING=4 on the 5th. The 5th is held. Drain in blanking emits addresses in push order, one per cycle.
- Simultaneous push/pop: PENDING=2 in blanking, WR_REQ=1 -> PENDING stays 2 for that cycle, MEM_WE=1 with the older entry.
- Reset mid-drain: PENDING=3, assert RESET_N=0 during drain -> MEM_WE=0 immediately; after release PENDING=0 and no stale writes appear.
